// File: rtl/cordic_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_sequencer
// Control sequencer for an iterative CORDIC sine/cosine core. A 16-bit phase
// word is accepted over a valid/ready handshake and folded into the first
// quadrant. The shared shift-add datapath is then driven through one LOAD
// step and ITERATIONS micro-rotations. The quadrant negate flags are then
// presented to post-processing under an output valid/ready handshake.
// ---------------------------------------------------------------------------
module cordic_sequencer #(
   parameter int ITERATIONS = 16,
   parameter int IDX_W      = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Clear_in,
   input  logic [15:0]      Phase_in,
   input  logic             In_valid,
   output logic             In_ready,
   output logic             Dp_load,
   output logic [15:0]      Dp_angle,
   output logic             Dp_iter_en,
   output logic [IDX_W-1:0] Dp_iter_idx,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic             Cos_negate,
   output logic             Sin_negate,
   output logic             Busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] ITER_LAST = IDX_W'(ITERATIONS - 1);

   state_t           r_state;
   logic             r_load;
   logic             r_iterEn;
   logic [IDX_W-1:0] r_iterIdx;
   logic             r_outValid;
   logic             r_busy;
   logic [15:0]      r_angle;
   logic             r_cosNeg;
   logic             r_sinNeg;

   logic [15:0]      w_foldAngle;
   logic             w_foldCos;
   logic             w_foldSin;
   logic             w_accept;

   // Quadrant fold of the incoming phase; the subtractions wrap modulo 2^16,
   // which is exactly the 17-bit result truncated to 16 bits.
   always_comb begin
      w_foldAngle = Phase_in;
      w_foldCos   = 1'b0;
      w_foldSin   = 1'b0;
      unique case (Phase_in[15:14])
         2'd0: begin
            w_foldAngle = Phase_in;
            w_foldCos   = 1'b0;
            w_foldSin   = 1'b0;
         end
         2'd1: begin
            w_foldAngle = 16'h8000 - Phase_in;
            w_foldCos   = 1'b1;
            w_foldSin   = 1'b0;
         end
         2'd2: begin
            w_foldAngle = Phase_in - 16'h8000;
            w_foldCos   = 1'b1;
            w_foldSin   = 1'b1;
         end
         2'd3: begin
            w_foldAngle = 16'h0000 - Phase_in;
            w_foldCos   = 1'b0;
            w_foldSin   = 1'b1;
         end
         default: begin
            w_foldAngle = Phase_in;
            w_foldCos   = 1'b0;
            w_foldSin   = 1'b0;
         end
      endcase
   end

   // Ready is the only combinational output: in DONE it follows Out_ready so
   // a new phase can be taken on the same edge as the result handshake.
   // An abort suppresses it so a clear never coincides with an acceptance.
   always_comb begin
      In_ready = 1'b0;
      if (!Clear_in) begin
         if (r_state == S_IDLE) begin
            In_ready = 1'b1;
         end else if (r_state == S_DONE) begin
            In_ready = Out_ready;
         end
      end
   end

   assign w_accept = In_ready && In_valid;

   // Main sequencer: state, strobes, index and latched fold results.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state    <= S_IDLE;
         r_load     <= 1'b0;
         r_iterEn   <= 1'b0;
         r_iterIdx  <= '0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
         r_angle    <= 16'h0000;
         r_cosNeg   <= 1'b0;
         r_sinNeg   <= 1'b0;
      end else if (Clear_in) begin
         r_state    <= S_IDLE;
         r_load     <= 1'b0;
         r_iterEn   <= 1'b0;
         r_iterIdx  <= '0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_angle  <= w_foldAngle;
                  r_cosNeg <= w_foldCos;
                  r_sinNeg <= w_foldSin;
                  r_load   <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_load    <= 1'b0;
               r_iterEn  <= 1'b1;
               r_iterIdx <= '0;
               r_state   <= S_ITER;
            end
            S_ITER: begin
               if (r_iterIdx == ITER_LAST) begin
                  r_iterEn   <= 1'b0;
                  r_iterIdx  <= '0;
                  r_outValid <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_iterIdx <= r_iterIdx + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (Out_ready) begin
                  r_outValid <= 1'b0;
                  if (w_accept) begin
                     r_angle  <= w_foldAngle;
                     r_cosNeg <= w_foldCos;
                     r_sinNeg <= w_foldSin;
                     r_load   <= 1'b1;
                     r_state  <= S_LOAD;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_load     <= 1'b0;
               r_iterEn   <= 1'b0;
               r_iterIdx  <= '0;
               r_outValid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign Dp_load     = r_load;
   assign Dp_angle    = r_angle;
   assign Dp_iter_en  = r_iterEn;
   assign Dp_iter_idx = r_iterIdx;
   assign Out_valid   = r_outValid;
   assign Cos_negate  = r_cosNeg;
   assign Sin_negate  = r_sinNeg;
   assign Busy        = r_busy;

endmodule

// File: tb/tb_cordic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cordic_sequencer
// Self-checking bench for cordic_sequencer: directed quadrant/edge vectors,
// backpressure, clear, async reset mid-operation and randomized phases
// against a behavioural quadrant-fold model.
// ---------------------------------------------------------------------------
module tb_cordic_sequencer;

   localparam int ITERS = 16;
   localparam int IW    = 4;

   logic          Clk;
   logic          Rst_n;
   logic          Clear_in;
   logic [15:0]   Phase_in;
   logic          In_valid;
   logic          In_ready;
   logic          Dp_load;
   logic [15:0]   Dp_angle;
   logic          Dp_iter_en;
   logic [IW-1:0] Dp_iter_idx;
   logic          Out_valid;
   logic          Out_ready;
   logic          Cos_negate;
   logic          Sin_negate;
   logic          Busy;

   int errCount;
   int checkCount;

   typedef struct {
      logic [15:0] phase;
      logic [15:0] angle;
      logic        cosN;
      logic        sinN;
   } vec_t;

   vec_t vecs [8];

   cordic_sequencer #(.ITERATIONS(ITERS), .IDX_W(IW)) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Clear_in    (Clear_in),
      .Phase_in    (Phase_in),
      .In_valid    (In_valid),
      .In_ready    (In_ready),
      .Dp_load     (Dp_load),
      .Dp_angle    (Dp_angle),
      .Dp_iter_en  (Dp_iter_en),
      .Dp_iter_idx (Dp_iter_idx),
      .Out_valid   (Out_valid),
      .Out_ready   (Out_ready),
      .Cos_negate  (Cos_negate),
      .Sin_negate  (Sin_negate),
      .Busy        (Busy)
   );

   // Free-running clock, 10 time-unit period.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference fold from the angle geometry: offset within the quarter turn,
   // mirrored in odd quadrants; cosine negative in quadrants 1-2, sine in 2-3.
   task automatic refFold(input logic [15:0] p, output logic [15:0] angle,
                          output logic cosN, output logic sinN);
      int q;
      int r;
      q = int'(p) / 16384;
      r = int'(p) % 16384;
      angle = ((q == 0) || (q == 2)) ? 16'(r) : 16'(16384 - r);
      cosN  = (q == 1) || (q == 2);
      sinN  = (q >= 2);
   endtask

   // Present a phase in IDLE; the accepting edge is the next rising edge.
   task automatic applyStimulus(input logic [15:0] p);
      @(negedge Clk);
      Phase_in = p;
      In_valid = 1'b1;
      #1;
      checkOutput("in_ready_idle", 32'(In_ready), 32'd1);
   endtask

   // Called in the cycle after the accepting edge: checks the LOAD cycle,
   // every iteration step, and the first DONE cycle.
   task automatic checkRun(input logic [15:0] expAngle, input logic expCos, input logic expSin);
      logic [15:0] keep;
      keep = Phase_in;
      checkOutput("load_strobe", 32'(Dp_load), 32'd1);
      checkOutput("load_iter_en", 32'(Dp_iter_en), 32'd0);
      checkOutput("load_out_valid", 32'(Out_valid), 32'd0);
      checkOutput("load_busy", 32'(Busy), 32'd1);
      checkOutput("load_angle", 32'(Dp_angle), 32'(expAngle));
      checkOutput("load_cos", 32'(Cos_negate), 32'(expCos));
      checkOutput("load_sin", 32'(Sin_negate), 32'(expSin));
      In_valid = 1'b0;
      #1;
      checkOutput("load_in_ready", 32'(In_ready), 32'd0);
      for (int i = 0; i < ITERS; i++) begin
         @(negedge Clk);
         if (i == 3) begin
            Phase_in = ~keep;
            In_valid = 1'b1;
         end
         if (i == 5) begin
            Phase_in = keep;
            In_valid = 1'b0;
         end
         checkOutput("iter_en", 32'(Dp_iter_en), 32'd1);
         checkOutput("iter_idx", 32'(Dp_iter_idx), 32'(i));
         checkOutput("iter_load", 32'(Dp_load), 32'd0);
         checkOutput("iter_out_valid", 32'(Out_valid), 32'd0);
         checkOutput("iter_in_ready", 32'(In_ready), 32'd0);
      end
      @(negedge Clk);
      checkOutput("done_valid", 32'(Out_valid), 32'd1);
      checkOutput("done_iter_en", 32'(Dp_iter_en), 32'd0);
      checkOutput("done_idx", 32'(Dp_iter_idx), 32'd0);
      checkOutput("done_angle", 32'(Dp_angle), 32'(expAngle));
      checkOutput("done_cos", 32'(Cos_negate), 32'(expCos));
      checkOutput("done_sin", 32'(Sin_negate), 32'(expSin));
      checkOutput("done_busy", 32'(Busy), 32'd1);
   endtask

   // Hold the result under backpressure for n cycles, checking it stays put.
   task automatic holdDone(input int n, input logic [15:0] expAngle, input logic expCos, input logic expSin);
      for (int i = 0; i < n; i++) begin
         Out_ready = 1'b0;
         #1;
         checkOutput("bp_in_ready", 32'(In_ready), 32'd0);
         @(negedge Clk);
         checkOutput("bp_valid", 32'(Out_valid), 32'd1);
         checkOutput("bp_angle", 32'(Dp_angle), 32'(expAngle));
         checkOutput("bp_cos", 32'(Cos_negate), 32'(expCos));
         checkOutput("bp_sin", 32'(Sin_negate), 32'(expSin));
      end
      Out_ready = 1'b1;
      #1;
      checkOutput("done_in_ready", 32'(In_ready), 32'd1);
   endtask

   // Release the result with no follow-on phase and confirm return to IDLE.
   task automatic finishToIdle();
      In_valid = 1'b0;
      @(negedge Clk);
      checkOutput("idle_valid", 32'(Out_valid), 32'd0);
      checkOutput("idle_busy", 32'(Busy), 32'd0);
      checkOutput("idle_in_ready", 32'(In_ready), 32'd1);
   endtask

   // Test sequence: reset, vector table, hand sequences, random traffic.
   initial begin
      logic [15:0] ea;
      logic        ec;
      logic        es;
      logic [15:0] cur;
      logic        sawValid;
      logic        found;
      int          delay;

      errCount   = 0;
      checkCount = 0;
      Rst_n      = 1'b0;
      Clear_in   = 1'b0;
      Phase_in   = 16'h0000;
      In_valid   = 1'b0;
      Out_ready  = 1'b1;

      vecs[0] = '{16'h2000, 16'h2000, 1'b0, 1'b0};
      vecs[1] = '{16'h6000, 16'h2000, 1'b1, 1'b0};
      vecs[2] = '{16'hA000, 16'h2000, 1'b1, 1'b1};
      vecs[3] = '{16'hE000, 16'h2000, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{16'h4000, 16'h4000, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'hC000, 16'h4000, 1'b0, 1'b1};

      // Power-on reset values.
      repeat (2) @(negedge Clk);
      checkOutput("rst_in_ready", 32'(In_ready), 32'd1);
      checkOutput("rst_load", 32'(Dp_load), 32'd0);
      checkOutput("rst_iter_en", 32'(Dp_iter_en), 32'd0);
      checkOutput("rst_idx", 32'(Dp_iter_idx), 32'd0);
      checkOutput("rst_angle", 32'(Dp_angle), 32'd0);
      checkOutput("rst_valid", 32'(Out_valid), 32'd0);
      checkOutput("rst_flags", 32'({Cos_negate, Sin_negate}), 32'd0);
      checkOutput("rst_busy", 32'(Busy), 32'd0);
      Rst_n = 1'b1;

      // Directed quadrant and boundary vectors.
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].phase);
         @(negedge Clk);
         checkRun(vecs[v].angle, vecs[v].cosN, vecs[v].sinN);
         finishToIdle();
      end

      // Backpressure for 5 cycles, then back-to-back acceptance.
      applyStimulus(16'h6000);
      @(negedge Clk);
      checkRun(16'h2000, 1'b1, 1'b0);
      holdDone(5, 16'h2000, 1'b1, 1'b0);
      Phase_in = 16'hA000;
      In_valid = 1'b1;
      @(negedge Clk);
      checkRun(16'h2000, 1'b1, 1'b1);
      finishToIdle();

      // Clear at iteration index 7, then a full fresh run.
      refFold(16'h5234, ea, ec, es);
      applyStimulus(16'h5234);
      @(negedge Clk);
      In_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge Clk);
         if (Dp_iter_en && Dp_iter_idx == IW'(7)) found = 1'b1;
      end
      checkOutput("clr_reach_idx7", 32'(found), 32'd1);
      Clear_in = 1'b1;
      @(negedge Clk);
      Clear_in = 1'b0;
      checkOutput("clr_busy", 32'(Busy), 32'd0);
      checkOutput("clr_iter_en", 32'(Dp_iter_en), 32'd0);
      checkOutput("clr_idx", 32'(Dp_iter_idx), 32'd0);
      checkOutput("clr_valid", 32'(Out_valid), 32'd0);
      checkOutput("clr_angle_kept", 32'(Dp_angle), 32'(ea));
      checkOutput("clr_flags_kept", 32'({Cos_negate, Sin_negate}), 32'({ec, es}));
      sawValid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (Out_valid || Busy) sawValid = 1'b1;
      end
      checkOutput("clr_no_result", 32'(sawValid), 32'd0);
      refFold(16'h9001, ea, ec, es);
      applyStimulus(16'h9001);
      @(negedge Clk);
      checkRun(ea, ec, es);
      finishToIdle();

      // Asynchronous reset in the middle of the iterations.
      applyStimulus(16'h3000);
      @(negedge Clk);
      In_valid = 1'b0;
      repeat (6) @(negedge Clk);
      checkOutput("arst_pre_iter", 32'(Dp_iter_en), 32'd1);
      Rst_n = 1'b0;
      #1;
      checkOutput("arst_iter_en", 32'(Dp_iter_en), 32'd0);
      checkOutput("arst_idx", 32'(Dp_iter_idx), 32'd0);
      checkOutput("arst_angle", 32'(Dp_angle), 32'd0);
      checkOutput("arst_busy", 32'(Busy), 32'd0);
      checkOutput("arst_in_ready", 32'(In_ready), 32'd1);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      checkOutput("arst_rel_in_ready", 32'(In_ready), 32'd1);
      checkOutput("arst_rel_valid", 32'(Out_valid), 32'd0);

      // Random phases with random backpressure and back-to-back handoff.
      cur = 16'($urandom);
      applyStimulus(cur);
      for (int n = 0; n < 24; n++) begin
         @(negedge Clk);
         refFold(cur, ea, ec, es);
         checkRun(ea, ec, es);
         delay = $urandom_range(0, 3);
         holdDone(delay, ea, ec, es);
         if (n < 23) begin
            cur = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               Phase_in = cur;
               In_valid = 1'b1;
            end else begin
               finishToIdle();
               Phase_in = cur;
               In_valid = 1'b1;
               #1;
               checkOutput("rnd_in_ready", 32'(In_ready), 32'd1);
            end
         end else begin
            finishToIdle();
         end
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
